// File: rtl/if_fetch_queue.sv
// Fetch-side request sequencer and instruction queue for the 32I pipeline.
// Issues single-outstanding imem requests and buffers {inst, pc, pc4} for ID.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] inst_addr,
  input  logic [31:0] pc4,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state, state_nxt;
  logic [AW:0]   count;
  logic [AW-1:0] head, tail;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_pc4  [DEPTH];
  logic [31:0]   fl_pc, fl_pc4;
  logic          space, issue, push, pop;

  // The in-flight slot is only possible from IDLE, so count alone bounds space;
  // a flush empties the queue before the issue decision.
  assign space    = pc_src ? 1'b1 : (count < DEPTH_C);
  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready && !pc_src;
  assign id_inst  = q_inst[head];
  assign id_pc    = q_pc[head];
  assign id_pc4   = q_pc4[head];

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    pc_we     = 1'b0;
    pc_next   = inst_addr;
    imem_req  = 1'b0;
    imem_addr = {inst_addr[31:2], 2'b00};
    case (state)
      IDLE: begin
        if (space) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (pc_src) begin
          pc_we     = 1'b1;
          state_nxt = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (pc_src) pc_we = 1'b1;
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      imem_req = 1'b1;
      pc_we    = 1'b1;
      pc_next  = pc4;
    end
    if (reset) begin
      issue    = 1'b0;
      push     = 1'b0;
      imem_req = 1'b0;
      pc_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      fl_pc  <= '0;
      fl_pc4 <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
        q_pc4[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (issue) begin
        fl_pc  <= inst_addr;
        fl_pc4 <= pc4;
      end
      if (pc_src) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) begin
          q_inst[tail] <= imem_rdata;
          q_pc[tail]   <= fl_pc;
          q_pc4[tail]  <= fl_pc4;
          tail         <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !push) count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] pc4 = 32'd4;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        pc_we, imem_req, id_valid;
  logic [31:0] pc_next, imem_addr, id_inst, id_pc, id_pc4;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .inst_addr(inst_addr), .pc4(pc4),
    .pc_we(pc_we), .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetched entries, plus whether a request is outstanding
  // and whether its response has been cancelled by a redirect.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy = 0;
  bit          m_disc = 0;
  logic [31:0] m_pc = '0, m_pc4 = '0;
  bit          exp_issue, exp_we, acked;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_busy = 0;
      m_disc = 0;
    end
    exp_issue = !reset && !m_busy && (pc_src || (mq.size() < DEPTH));
    exp_we    = exp_issue || (!reset && pc_src && m_busy);
    chk("imem_req", 32'(imem_req), 32'(exp_issue));
    if (exp_issue) chk("imem_addr", imem_addr, inst_addr & 32'hFFFF_FFFC);
    chk("pc_we", 32'(pc_we), 32'(exp_we));
    if (exp_we) chk("pc_next", pc_next, exp_issue ? pc4 : inst_addr);
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_inst", id_inst, mq[0].inst);
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_pc4", id_pc4, mq[0].pc4);
    end
    if (reset) begin
      chk("rst_id_inst", id_inst, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_pc4", id_pc4, 32'h0);
    end else begin
      acked = m_busy && imem_ack;
      if (pc_src) begin
        mq.delete();
        if (acked) begin
          m_busy = 0;
          m_disc = 0;
        end else if (m_busy) begin
          m_disc = 1;
        end
      end else begin
        if (mq.size() != 0 && id_ready) void'(mq.pop_front());
        if (acked) begin
          if (!m_disc) mq.push_back('{imem_rdata, m_pc, m_pc4});
          m_busy = 0;
          m_disc = 0;
        end
      end
      if (exp_issue) begin
        m_busy = 1;
        m_disc = 0;
        m_pc   = inst_addr;
        m_pc4  = pc4;
      end
    end
  end

  // Inputs change just after a rising edge; checks happen at the falling edge.
  task automatic step(input logic src, input logic [31:0] addr, input logic ack,
                      input logic [31:0] rd, input logic rdy);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    pc_src     = src;
    inst_addr  = addr;
    pc4        = addr + 32'd4;
    imem_ack   = ack;
    imem_rdata = rd;
    id_ready   = rdy;
    @(negedge clk);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset    = 1'b1;
      pc_src   = 1'b0;
      imem_ack = 1'b0;
      id_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    // Basic fetch with a slow response
    rst_cycles(2);
    chk("t1_rst_valid", 32'(id_valid), 32'h0);
    chk("t1_rst_req", 32'(imem_req), 32'h0);
    chk("t1_rst_we", 32'(pc_we), 32'h0);
    chk("t1_rst_inst", id_inst, 32'h0);
    step(0, 32'h0, 0, 0, 0);
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_we", 32'(pc_we), 32'h1);
    chk("t1_next", pc_next, 32'h4);
    step(0, 32'h4, 0, 0, 0);
    step(0, 32'h4, 0, 0, 0);
    step(0, 32'h4, 1, 32'h13, 0);
    chk("t1_valid_at_ack", 32'(id_valid), 32'h0);
    step(0, 32'h4, 0, 0, 0);
    chk("t1_valid", 32'(id_valid), 32'h1);
    chk("t1_inst", id_inst, 32'h13);
    chk("t1_pc", id_pc, 32'h0);
    chk("t1_pc4", id_pc4, 32'h4);

    // Backpressure: two issues fill DEPTH=2, then a pop re-opens space a cycle later
    rst_cycles(1);
    step(0, 32'h40, 0, 0, 0);
    chk("t2_req0", 32'(imem_req), 32'h1);
    step(0, 32'h44, 1, 32'h1, 0);
    chk("t2_req_wait", 32'(imem_req), 32'h0);
    step(0, 32'h44, 0, 0, 0);
    chk("t2_req1", 32'(imem_req), 32'h1);
    step(0, 32'h48, 1, 32'h2, 0);
    step(0, 32'h48, 0, 0, 0);
    chk("t2_full_req", 32'(imem_req), 32'h0);
    step(0, 32'h48, 0, 0, 0);
    chk("t2_full_req2", 32'(imem_req), 32'h0);
    step(0, 32'h48, 0, 0, 1);
    chk("t2_pop_req", 32'(imem_req), 32'h0);
    chk("t2_pop_inst", id_inst, 32'h1);
    step(0, 32'h48, 0, 0, 0);
    chk("t2_after_pop_req", 32'(imem_req), 32'h1);
    chk("t2_after_pop_addr", imem_addr, 32'h48);
    chk("t2_head", id_inst, 32'h2);

    // Redirect while full and idle: flush and issue to target same cycle
    rst_cycles(1);
    step(0, 32'h40, 0, 0, 0);
    step(0, 32'h44, 1, 32'h1, 0);
    step(0, 32'h44, 0, 0, 0);
    step(0, 32'h48, 1, 32'h2, 0);
    step(1, 32'h200, 0, 0, 1);
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_next", pc_next, 32'h204);
    chk("t4_valid_old", 32'(id_valid), 32'h1);
    step(0, 32'h204, 0, 0, 0);
    chk("t4_valid", 32'(id_valid), 32'h0);
    step(0, 32'h204, 1, 32'h77, 0);
    step(0, 32'h208, 0, 0, 0);
    chk("t4_inst", id_inst, 32'h77);
    chk("t4_pc", id_pc, 32'h200);

    // Redirect while waiting: response dropped, refetch from target
    rst_cycles(1);
    step(0, 32'h40, 0, 0, 0);
    step(1, 32'h100, 0, 0, 0);
    chk("t3_we", 32'(pc_we), 32'h1);
    chk("t3_next", pc_next, 32'h100);
    chk("t3_req", 32'(imem_req), 32'h0);
    step(0, 32'h100, 0, 0, 0);
    chk("t3_drop_req", 32'(imem_req), 32'h0);
    step(0, 32'h100, 1, 32'hDEAD_BEEF, 0);
    step(0, 32'h100, 0, 0, 0);
    chk("t3_valid", 32'(id_valid), 32'h0);
    chk("t3_req2", 32'(imem_req), 32'h1);
    chk("t3_addr2", imem_addr, 32'h100);
    step(0, 32'h104, 1, 32'h33, 0);
    step(0, 32'h104, 0, 0, 0);
    chk("t3_inst", id_inst, 32'h33);
    chk("t3_pc4", id_pc4, 32'h104);

    // Simultaneous push and pop with one entry queued
    rst_cycles(1);
    step(0, 32'h10, 0, 0, 0);
    step(0, 32'h14, 1, 32'hA1, 0);
    step(0, 32'h14, 0, 0, 0);
    chk("t5_head0", id_inst, 32'hA1);
    step(0, 32'h18, 1, 32'hA2, 1);
    step(0, 32'h18, 0, 0, 0);
    chk("t5_valid", 32'(id_valid), 32'h1);
    chk("t5_inst", id_inst, 32'hA2);
    chk("t5_pc", id_pc, 32'h14);
    chk("t5_pc4", id_pc4, 32'h18);
    chk("t5_req", 32'(imem_req), 32'h1);
    step(0, 32'h1C, 0, 0, 1);
    step(0, 32'h1C, 0, 0, 0);
    chk("t5_empty", 32'(id_valid), 32'h0);

    // Reset while a request is outstanding
    rst_cycles(1);
    step(0, 32'h20, 0, 0, 0);
    chk("t6_req", 32'(imem_req), 32'h1);
    rst_cycles(1);
    chk("t6_rst_we", 32'(pc_we), 32'h0);
    chk("t6_rst_req", 32'(imem_req), 32'h0);
    step(0, 32'h300, 1, 32'h55, 0);
    chk("t6_req2", 32'(imem_req), 32'h1);
    chk("t6_addr2", imem_addr, 32'h300);
    step(0, 32'h304, 0, 0, 0);
    chk("t6_valid", 32'(id_valid), 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      reset      = ($urandom_range(0, 499) == 0);
      pc_src     = ($urandom_range(0, 15) == 0);
      inst_addr  = $urandom;
      pc4        = inst_addr + 32'd4;
      imem_ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      imem_rdata = $urandom;
      id_ready   = $urandom_range(0, 1) == 1;
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
